serial_word_assembler: RTL and testbench
========================================

Name: serial_word_assembler

Overview:
- Downstream consumer of the single-bit D flip-flop stage.
- Samples the registered serial bit stream (flip-flop q) under a qualifier and assembles WIDTH-bit words, MSB first.
- Presents each completed word with a valid/ready handshake to the next register-file/ALU stage.
- Flags lost words (overrun), with optional per-word even-parity checking.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  rising-edge clock; all state changes on posedge clock.
- not_clear  input  1  synchronous, active-low reset; sampled on posedge clock.
- bit_in  input  1  serial data bit, driven from the upstream flip-flop q.
- bit_valid  input  1  bit_in is sampled on a clock edge only when this is 1.
- word_out  output  WIDTH  assembled word; first-received bit is at word_out[WIDTH-1].
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer accepts word_out on an edge where word_valid=1 and word_ready=1.
- overrun  output  1  sticky; set when a completed word is dropped.
- parity_error  output  1  parity status of the word currently on word_out.

Behaviour:
- Reset (not_clear=0 at posedge clock):
  - word_out=0, word_valid=0, overrun=0, parity_error=0.
  - Shift register and bit counter cleared; FSM goes to S_DATA.
  - Reset has priority over all other inputs. Reset mid-word discards all partial bits.
  - Asserting not_clear asynchronously has no effect until the next edge.
- Shift register: on an accepted bit, shift_reg <= {shift_reg[WIDTH-2:0], bit_in}. Counter increments.
- bit_valid=0: shift register, counter and FSM hold.
- FSM states:
  - S_DATA: collects WIDTH bits. On the WIDTH-th accepted bit (counter==WIDTH-1 && bit_valid), the frame completes (macro off) or the FSM moves to S_PARITY (macro on). Counter wraps to 0.
  - S_PARITY: exists only when PARITY_CHECK_EN is defined. The next accepted bit is the parity bit; frame completes; FSM returns to S_DATA.
- Frame completion at edge N:
  - If word_valid=0, or word_valid=1 with word_ready=1 at edge N: word_out <= completed word and word_valid=1 after edge N. Latency is zero extra cycles after the last bit edge.
  - If word_valid=1 and word_ready=0 at edge N: the new word is dropped, word_out is unchanged, and overrun <= 1. overrun stays 1 until reset.
- Handshake:
  - word_valid falls after an edge with word_ready=1 and no simultaneous completion.
  - word_out is stable while word_valid=1 and not accepted.
  - word_ready while word_valid=0 is ignored.
- Back-to-back: collection continues while a word waits. A simultaneous accept and complete keeps word_valid=1 with the new data.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - Frame is WIDTH+1 bits; the last bit is even parity over the data.
  - On completion, parity_error <= (^data) ^ parity_bit. It is loaded together with word_out and held with it.
  - A dropped word does not update parity_error.
- Undefined:
  - Frame is WIDTH bits; S_PARITY is not generated.
  - parity_error is tied to 0. The port is still present.

Decomposition:
- Shared constants file/package holds:
  - FSM state encodings S_DATA=1'b0, S_PARITY=1'b1.
  - Default WIDTH and CNT_W.
- One natural sub-module: bit_counter.
  - Inputs: clock, not_clear, enable (bit_valid), wrap (terminal count).
  - Output: count.
  - Synchronous active-low clear, same reset convention as this block.

Test Plan:
1. WIDTH=8, macro off; reset then bits 1,0,1,1,0,0,1,0 with bit_valid=1, word_ready=1 -> word_valid=1 after the 8th edge, word_out=8'hB2; word_valid=0 one cycle later.
2. Interleave bit_valid=0 gaps of 1–3 cycles within the stream 8'h5A -> word_out=8'h5A; counter holds during gaps; no extra word.
3. word_ready=0; send 8'h11 then 8'h22 -> word_out stays 8'h11, overrun=1 after the 16th bit edge; raise word_ready -> 8'h11 accepted, overrun remains 1.
4. word_ready=1 exactly on the edge where the second word completes (8'hC3 then 8'h3C) -> word_valid stays 1, word_out=8'h3C, overrun=0.
5. Send 5 bits, assert not_clear=0 for one edge, then send 8'hF0 -> only 8'hF0 delivered; all outputs 0 during and immediately after reset.
6. Macro on; send 8'hB2 + parity 0 -> parity_error=0. Send 8'hB2 + parity 1 -> parity_error=1 with word_out=8'hB2 after the 9th edge.

Source files
------------

// File: rtl/serial_word_assembler_pkg.sv
// Shared FSM state encodings and default sizing for the serial word assembler.
package serial_word_assembler_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_CNT_W = 4;

  typedef enum logic {
    S_DATA   = 1'b0,
    S_PARITY = 1'b1
  } state_t;

endpackage

// File: rtl/serial_word_assembler_bit_counter.sv
// Data-bit counter for the serial word assembler; synchronous active-low clear,
// advances on enable and returns to zero when enabled at terminal count.
module serial_word_assembler_bit_counter
  import serial_word_assembler_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             not_clear,
  input  logic             enable,
  input  logic             wrap,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!not_clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= wrap ? '0 : r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/serial_word_assembler.sv
// Assembles MSB-first serial bits into WIDTH-bit words with valid/ready output,
// sticky overrun flag; optional even-parity frame bit under `PARITY_CHECK_EN.
module serial_word_assembler
  import serial_word_assembler_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             not_clear,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun,
  output logic             parity_error
);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_ovr;
  logic             r_perr;

  logic [CNT_W-1:0] w_count;
  logic             w_last;
  logic             w_data_bit;
  logic             w_complete;
  logic [WIDTH-1:0] w_data_next;
  logic [WIDTH-1:0] w_frame_word;
  logic             w_frame_perr;

  assign w_last      = (w_count == CNT_W'(WIDTH - 1));
  assign w_data_bit  = bit_valid && (r_state == S_DATA);
  assign w_data_next = {r_shift[WIDTH-2:0], bit_in};

`ifdef PARITY_CHECK_EN
  // The parity bit is not shifted in; data already sits in r_shift.
  assign w_complete   = bit_valid && (r_state == S_PARITY);
  assign w_frame_word = r_shift;
  assign w_frame_perr = (^r_shift) ^ bit_in;
`else
  assign w_complete   = w_data_bit && w_last;
  assign w_frame_word = w_data_next;
  assign w_frame_perr = 1'b0;
`endif

  serial_word_assembler_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clock     (clock),
    .not_clear (not_clear),
    .enable    (w_data_bit),
    .wrap      (w_last),
    .count     (w_count)
  );

  always_ff @(posedge clock) begin
    if (!not_clear) begin
      r_state <= S_DATA;
      r_shift <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      if (w_data_bit) begin
        r_shift <= w_data_next;
      end

`ifdef PARITY_CHECK_EN
      if (w_data_bit && w_last) begin
        r_state <= S_PARITY;
      end else if (w_complete) begin
        r_state <= S_DATA;
      end
`else
      r_state <= S_DATA;
`endif

      // A completed word replaces the held one only if that one is free or leaving now.
      if (w_complete) begin
        if (!r_valid || word_ready) begin
          r_word  <= w_frame_word;
          r_valid <= 1'b1;
          r_perr  <= w_frame_perr;
        end else begin
          r_ovr   <= 1'b1;
        end
      end else if (word_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign word_out     = r_word;
  assign word_valid   = r_valid;
  assign overrun      = r_ovr;
  assign parity_error = r_perr;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based frame model.
module tb_serial_word_assembler;

  localparam int unsigned WIDTH = 8;
`ifdef PARITY_CHECK_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif

  logic             clock = 1'b0;
  logic             not_clear = 1'b0;
  logic             bit_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic             word_ready = 1'b0;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             overrun;
  logic             parity_error;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  bit               m_q[$];
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_word  = '0;
  logic             m_ovr   = 1'b0;
  logic             m_perr  = 1'b0;

  serial_word_assembler #(
    .WIDTH (WIDTH),
    .CNT_W (4)
  ) dut (
    .clock        (clock),
    .not_clear    (not_clear),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .overrun      (overrun),
    .parity_error (parity_error)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: a word exists once FRAME accepted bits have arrived.
  task automatic model_edge(input logic nc, input logic bv, input logic b, input logic rdy);
    logic             done;
    logic [WIDTH-1:0] d;
    logic             pe;
    int unsigned      ones;
    done = 1'b0;
    d    = '0;
    pe   = 1'b0;
    ones = 0;
    if (!nc) begin
      m_q.delete();
      m_valid = 1'b0;
      m_word  = '0;
      m_ovr   = 1'b0;
      m_perr  = 1'b0;
    end else begin
      if (bv) begin
        m_q.push_back(b);
        if (m_q.size() == FRAME) begin
          for (int i = 0; i < int'(WIDTH); i++) d = (d << 1) | WIDTH'(m_q[i]);
          foreach (m_q[k]) ones += int'(m_q[k]);
`ifdef PARITY_CHECK_EN
          pe = (ones % 2) != 0;
`endif
          m_q.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (!m_valid || rdy) begin
          m_word  = d;
          m_valid = 1'b1;
          m_perr  = pe;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (rdy) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic step(input logic nc, input logic bv, input logic b, input logic rdy);
    not_clear  = nc;
    bit_valid  = bv;
    bit_in     = b;
    word_ready = rdy;
    @(posedge clock);
    model_edge(nc, bv, b, rdy);
    #1;
    check_eq("word_valid", 32'(word_valid), 32'(m_valid));
    check_eq("word_out", 32'(word_out), 32'(m_word));
    check_eq("overrun", 32'(overrun), 32'(m_ovr));
    check_eq("parity_error", 32'(parity_error), 32'(m_perr));
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy_body, input logic rdy_last,
                           input int unsigned max_gap, input logic bad_par);
    logic [8:0] fr;
    int         nb;
`ifdef PARITY_CHECK_EN
    fr = {w, (^w) ^ bad_par};
    nb = 9;
`else
    fr = {1'b0, w};
    nb = 8;
    if (bad_par) fr[8] = 1'b0;
`endif
    for (int i = nb - 1; i >= 0; i--) begin
      repeat ($urandom_range(max_gap, 0)) step(1'b1, 1'b0, 1'($urandom), rdy_body);
      step(1'b1, 1'b1, fr[i], (i == 0) ? rdy_last : rdy_body);
    end
  endtask

  initial begin
    logic [7:0] partial;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("reset_valid", 32'(word_valid), 32'd0);
    check_eq("reset_word", 32'(word_out), 32'd0);

    // Basic word, handshake drop
    send_word(8'hB2, 1'b1, 1'b1, 0, 1'b0);
    check_eq("t1_word", 32'(word_out), 32'hB2);
    check_eq("t1_valid", 32'(word_valid), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("t1_valid_drop", 32'(word_valid), 32'd0);

    // Gaps inside the stream
    send_word(8'h5A, 1'b1, 1'b1, 3, 1'b0);
    check_eq("t2_word", 32'(word_out), 32'h5A);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Overrun while the first word waits
    send_word(8'h11, 1'b0, 1'b0, 0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 0, 1'b0);
    check_eq("t3_word_held", 32'(word_out), 32'h11);
    check_eq("t3_overrun", 32'(overrun), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("t3_accepted", 32'(word_valid), 32'd0);
    check_eq("t3_overrun_sticky", 32'(overrun), 32'd1);

    // Accept coincident with completion
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'hC3, 1'b0, 1'b0, 0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b1, 0, 1'b0);
    check_eq("t4_valid", 32'(word_valid), 32'd1);
    check_eq("t4_word", 32'(word_out), 32'h3C);
    check_eq("t4_overrun", 32'(overrun), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-word discards partial bits
    partial = 8'hFF;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, partial[i], 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("t5_rst_valid", 32'(word_valid), 32'd0);
    check_eq("t5_rst_word", 32'(word_out), 32'd0);
    check_eq("t5_rst_ovr", 32'(overrun), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t5_post_valid", 32'(word_valid), 32'd0);
    check_eq("t5_post_word", 32'(word_out), 32'd0);
    send_word(8'hF0, 1'b1, 1'b1, 0, 1'b0);
    check_eq("t5_word", 32'(word_out), 32'hF0);
    check_eq("t5_valid", 32'(word_valid), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1);

`ifdef PARITY_CHECK_EN
    send_word(8'hB2, 1'b1, 1'b1, 0, 1'b0);
    check_eq("t6_par_ok", 32'(parity_error), 32'd0);
    check_eq("t6_word_ok", 32'(word_out), 32'hB2);
    send_word(8'hB2, 1'b1, 1'b1, 0, 1'b1);
    check_eq("t6_par_bad", 32'(parity_error), 32'd1);
    check_eq("t6_word_bad", 32'(word_out), 32'hB2);
    step(1'b1, 1'b0, 1'b0, 1'b1);
`endif

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(99, 0) != 0), ($urandom_range(9, 0) < 7),
           1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
